// File: rtl/x_corr.sv
// Complex circular cross-correlator: captures one frame of x/y samples, reports peak |C[k]| and its lag.
// Define X_CORR_LINEAR_LAG_EN for zero-padded (linear) correlation instead of circular.
module x_corr #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int i_bits              = 24,
    parameter int q_bits              = 24,
    parameter int length              = 5,
    parameter int length_counter_bits = 3,
    parameter int out_max_bits        = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           m_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic signed [xi_bits-1:0]      xi,
    input  logic signed [xq_bits-1:0]      xq,
    input  logic signed [yi_bits-1:0]      yi,
    input  logic signed [yq_bits-1:0]      yq,
    output logic                           s_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [out_max_bits-1:0]        out_max,
    output logic [length_counter_bits-1:0] index
);

    localparam int LCB = length_counter_bits;
    localparam int MB  = ((i_bits > q_bits) ? i_bits : q_bits) + 1;
    localparam int SH  = (out_max_bits < MB) ? (MB - out_max_bits) : 0;
    localparam logic [LCB-1:0] LAST = LCB'(length - 1);
    localparam logic [LCB:0]   LEN  = (LCB+1)'(length);

    typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

    state_t state, state_next;

    logic [LCB-1:0] sample_cnt, n, lag, m, max_lag, lag_best;
    logic [LCB:0]   idx_sum;
    logic           skip, accept;

    logic signed [xi_bits-1:0] xi_buf [length];
    logic signed [xq_bits-1:0] xq_buf [length];
    logic signed [yi_bits-1:0] yi_buf [length];
    logic signed [yq_bits-1:0] yq_buf [length];

    logic signed [i_bits-1:0] acc_i, acc_i_next, p_ii, p_qq, term_i;
    logic signed [q_bits-1:0] acc_q, acc_q_next, p_qi, p_iq, term_q;
    logic signed [MB-1:0]     ext_i, ext_q;
    logic [MB-1:0]            abs_i, abs_q, mag, max_mag, max_next;

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        s_axis_tready = 1'b0;
        s_axis_tvalid = 1'b0;
        case (state)
            LOAD: begin
                s_axis_tready = !reset;
                if (m_axis_tvalid && !reset && sample_cnt == LAST) state_next = COMPUTE;
            end
            COMPUTE: if (n == LAST && lag == LAST) state_next = DONE;
            DONE: begin
                s_axis_tvalid = 1'b1;
                if (m_axis_tready) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    assign accept = m_axis_tvalid && s_axis_tready;

    always_comb begin
        idx_sum = {1'b0, n} + {1'b0, lag};
        m       = (idx_sum >= LEN) ? LCB'(idx_sum - LEN) : LCB'(idx_sum);
`ifdef X_CORR_LINEAR_LAG_EN
        skip    = (idx_sum >= LEN);
`else
        skip    = 1'b0;
`endif
        // Operands widened to accumulator width so products keep full precision.
        p_ii   = i_bits'(xi_buf[n]) * i_bits'(yi_buf[m]);
        p_qq   = i_bits'(xq_buf[n]) * i_bits'(yq_buf[m]);
        p_qi   = q_bits'(xq_buf[n]) * q_bits'(yi_buf[m]);
        p_iq   = q_bits'(xi_buf[n]) * q_bits'(yq_buf[m]);
        term_i = skip ? '0 : (p_ii + p_qq);
        term_q = skip ? '0 : (p_qi - p_iq);
        acc_i_next = acc_i + term_i;
        acc_q_next = acc_q + term_q;

        ext_i    = MB'(acc_i_next);
        ext_q    = MB'(acc_q_next);
        abs_i    = ext_i[MB-1] ? -ext_i : ext_i;
        abs_q    = ext_q[MB-1] ? -ext_q : ext_q;
        mag      = abs_i + abs_q;
        max_next = (mag > max_mag) ? mag : max_mag;
        lag_best = (mag > max_mag) ? lag : max_lag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt <= '0;
            n          <= '0;
            lag        <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            max_mag    <= '0;
            max_lag    <= '0;
            out_max    <= '0;
            index      <= '0;
            for (int unsigned i = 0; i < length; i++) begin
                xi_buf[i] <= '0;
                xq_buf[i] <= '0;
                yi_buf[i] <= '0;
                yq_buf[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: if (accept) begin
                    xi_buf[sample_cnt] <= xi;
                    xq_buf[sample_cnt] <= xq;
                    yi_buf[sample_cnt] <= yi;
                    yq_buf[sample_cnt] <= yq;
                    if (sample_cnt == LAST) begin
                        sample_cnt <= '0;
                        n          <= '0;
                        lag        <= '0;
                        acc_i      <= '0;
                        acc_q      <= '0;
                        max_mag    <= '0;
                        max_lag    <= '0;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (n == LAST) begin
                        n       <= '0;
                        acc_i   <= '0;
                        acc_q   <= '0;
                        max_mag <= max_next;
                        max_lag <= lag_best;
                        if (lag == LAST) begin
                            lag     <= '0;
                            out_max <= out_max_bits'(max_next >> SH);
                            index   <= lag_best;
                        end else begin
                            lag <= lag + 1'b1;
                        end
                    end else begin
                        n     <= n + 1'b1;
                        acc_i <= acc_i_next;
                        acc_q <= acc_q_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_x_corr.sv
// Randomized self-checking bench for x_corr against a direct correlation-sum model.
module tb_x_corr;

    localparam int L  = 5;
    localparam int OB = 25;

    logic clk = 1'b0;
    logic reset;
    logic m_axis_tvalid, s_axis_tready, s_axis_tvalid, m_axis_tready;
    logic signed [11:0] xi, xq, yi, yq;
    logic [OB-1:0] out_max;
    logic [2:0]    index;

    int vectors = 0;
    int miscompares = 0;

    int fxi [L];
    int fxq [L];
    int fyi [L];
    int fyq [L];

    always #5 clk = ~clk;

    x_corr #(.out_max_bits(OB)) dut (
        .clk(clk), .reset(reset),
        .m_axis_tvalid(m_axis_tvalid), .s_axis_tready(s_axis_tready),
        .xi(xi), .xq(xq), .yi(yi), .yq(yq),
        .s_axis_tvalid(s_axis_tvalid), .m_axis_tready(m_axis_tready),
        .out_max(out_max), .index(index)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrap24(input longint v);
        longint r;
        r = v & 64'hFF_FFFF;
        if (r >= 64'sd8388608) r = r - 64'sd16777216;
        return r;
    endfunction

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Direct evaluation of every lag's correlation sum; strict > keeps the earliest peak.
    task automatic model(output longint em, output int ei);
        longint ai, aq, mg;
        int mm;
        em = 0;
        ei = 0;
        for (int k = 0; k < L; k++) begin
            ai = 0;
            aq = 0;
            for (int j = 0; j < L; j++) begin
                mm = (j + k) % L;
`ifdef X_CORR_LINEAR_LAG_EN
                if (j + k >= L) continue;
`endif
                ai += longint'(fxi[j]) * fyi[mm] + longint'(fxq[j]) * fyq[mm];
                aq += longint'(fxq[j]) * fyi[mm] - longint'(fxi[j]) * fyq[mm];
            end
            mg = absl(wrap24(ai)) + absl(wrap24(aq));
            if (mg > em) begin
                em = mg;
                ei = k;
            end
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < L; i++) begin
            fxi[i] = 0; fxq[i] = 0; fyi[i] = 0; fyq[i] = 0;
        end
    endtask

    task automatic rand_frame(input int span);
        for (int i = 0; i < L; i++) begin
            fxi[i] = int'($urandom_range(0, 2 * span)) - span;
            fxq[i] = int'($urandom_range(0, 2 * span)) - span;
            fyi[i] = int'($urandom_range(0, 2 * span)) - span;
            fyq[i] = int'($urandom_range(0, 2 * span)) - span;
        end
    endtask

    task automatic load_frame();
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                m_axis_tvalid = 1'b0;
                @(negedge clk);
            end
            xi = 12'(fxi[i]); xq = 12'(fxq[i]);
            yi = 12'(fyi[i]); yq = 12'(fyq[i]);
            m_axis_tvalid = 1'b1;
            if (!s_axis_tready) check("tready_load", s_axis_tready, 1);
            @(posedge clk);
        end
    endtask

    task automatic run_frame(input int hold, output longint got_max, output int got_idx);
        int cyc;
        bit busy_bad;
        longint em;
        int ei;
        model(em, ei);
        load_frame();
        cyc = 0;
        busy_bad = 1'b0;
        // Garbage on the input and result handshakes while computing must be ignored.
        do begin
            @(negedge clk);
            cyc++;
            if (!s_axis_tvalid && s_axis_tready) busy_bad = 1'b1;
            m_axis_tvalid = 1'($urandom_range(0, 1));
            m_axis_tready = 1'($urandom_range(0, 1));
            xi = 12'($urandom); yi = 12'($urandom);
        end while (!s_axis_tvalid && cyc < 200);
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        check("latency", cyc, L * L + 1);
        check("tready_busy", busy_bad, 0);
        check("out_max", out_max, em);
        check("index", index, ei);
        check("tready_done", s_axis_tready, 0);
        got_max = out_max;
        got_idx = index;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_tvalid", s_axis_tvalid, 1);
            check("hold_out_max", out_max, em);
            check("hold_tready", s_axis_tready, 0);
        end
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
        check("post_tvalid", s_axis_tvalid, 0);
        check("post_tready", s_axis_tready, 1);
        check("post_retain", out_max, em);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint gm;
        int gi;
        reset = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        repeat (3) @(negedge clk);
        check("reset_tready", s_axis_tready, 0);
        check("reset_tvalid", s_axis_tvalid, 0);
        check("reset_out_max", out_max, 0);
        check("reset_index", index, 0);
        reset = 1'b0;
        @(negedge clk);
        check("release_tready", s_axis_tready, 1);

        clear_frame(); fxi[0] = 100; fyi[0] = 100;
        run_frame(0, gm, gi);
        check("impulse_max", gm, 10000);
        check("impulse_idx", gi, 0);

        clear_frame(); fxi[0] = 100; fyi[3] = 50;
        run_frame(0, gm, gi);
        check("delay_max", gm, 5000);
        check("delay_idx", gi, 3);

        clear_frame(); fxq[0] = 100; fyi[0] = 100;
        run_frame(0, gm, gi);
        check("quad_max", gm, 10000);

        clear_frame();
        run_frame(0, gm, gi);
        check("zero_max", gm, 0);
        check("zero_idx", gi, 0);

        clear_frame(); fxi[3] = 100; fyi[0] = 100;
        run_frame(0, gm, gi);
`ifdef X_CORR_LINEAR_LAG_EN
        check("lag_mode_max", gm, 0);
        check("lag_mode_idx", gi, 0);
`else
        check("lag_mode_max", gm, 10000);
        check("lag_mode_idx", gi, 2);
`endif

        rand_frame(300);
        run_frame(10, gm, gi);
        rand_frame(300);
        run_frame(0, gm, gi);

        for (int f = 0; f < 8; f++) begin
            rand_frame((f % 2 == 0) ? 2048 : 40);
            if (f % 2 == 0) begin
                fxi[0] = -2048; fyi[0] = -2048; fxq[1] = -2048; fyq[1] = -2048;
            end
            run_frame($urandom_range(0, 3), gm, gi);
        end

        // Abort a frame mid-compute; the partial result must be discarded.
        rand_frame(500);
        load_frame();
        m_axis_tvalid = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tready", s_axis_tready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_tvalid", s_axis_tvalid, 0);
        check("midreset_tready_rel", s_axis_tready, 1);
        check("midreset_out_max", out_max, 0);
        check("midreset_index", index, 0);

        clear_frame(); fxi[0] = 100; fyi[0] = 100;
        run_frame(0, gm, gi);
        check("fresh_max", gm, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/x_corr.md
Name: x_corr

Overview:
- Complex cross-correlator that captures one frame of `length` x samples and `length` y samples.
- Computes the circular correlation C[k] = sum_n x[n]*conj(y[(n+k) mod length]) for every lag k = 0..length-1.
- Reports the largest magnitude and the lag that produced it.
- Sits downstream of the frequency shifter inside a CAF slice; one instance per frequency bin.

Parameters:
- xi_bits, 12, width of signed x in-phase input
- xq_bits, 12, width of signed x quadrature input
- yi_bits, 12, width of signed y in-phase input
- yq_bits, 12, width of signed y quadrature input
- i_bits, 24, width of signed in-phase accumulator
- q_bits, 24, width of signed quadrature accumulator
- length, 5, samples per frame and number of lags
- length_counter_bits, 3, width of sample/lag counters and of index
- out_max_bits, 5, width of reported peak magnitude

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- m_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  block accepts a sample this cycle
- xi  in  xi_bits  signed x in-phase
- xq  in  xq_bits  signed x quadrature
- yi  in  yi_bits  signed y in-phase
- yq  in  yq_bits  signed y quadrature
- s_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  consumer accepts result
- out_max  out  out_max_bits  peak magnitude, scaled
- index  out  length_counter_bits  lag of peak

Behaviour:
- Interface: single clock clk; synchronous active-high reset.
- Reset:
  - State goes to LOAD; all counters, buffers, accumulators and max are cleared.
  - out_max=0, index=0, s_axis_tvalid=0.
  - s_axis_tready=0 while reset is high; 1 on the first cycle after release.
- States: LOAD, COMPUTE, DONE.
- LOAD:
  - s_axis_tready=1.
  - On m_axis_tvalid&&s_axis_tready, store (xi,xq,yi,yq) at position sample_cnt and increment sample_cnt.
  - When the length-th sample is accepted, go to COMPUTE and clear lag, n, accumulators and max.
- COMPUTE:
  - s_axis_tready=0.
  - One complex MAC per cycle: acc_i += xi[n]*yi[m] + xq[n]*yq[m]; acc_q += xq[n]*yi[m] - xi[n]*yq[m]; m=(n+lag) mod length.
  - Products are full precision, sign-extended to the accumulator width.
  - Accumulators wrap in two's complement.
- End of each lag (after length MACs):
  - mag = |acc_i| + |acc_q|, width MB = max(i_bits,q_bits)+1, unsigned.
  - If mag > max_mag (strict), update max_mag and max_lag. Ties keep the earlier (lower) lag.
  - Clear the accumulators and advance the lag.
- After lag length-1 is evaluated:
  - out_max = max_mag >> (MB-out_max_bits) when out_max_bits < MB; otherwise max_mag zero-extended.
  - index = max_lag.
  - Go to DONE.
- Latency: s_axis_tvalid rises length*length+1 cycles after the cycle the last sample is accepted.
- DONE:
  - s_axis_tvalid=1; out_max and index held stable.
  - Held until m_axis_tready=1. On that cycle (handshake) go to LOAD.
  - s_axis_tvalid=0 and s_axis_tready=1 the next cycle.
- m_axis_tvalid is ignored outside LOAD; no samples are lost or duplicated.
- m_axis_tready is ignored outside DONE.
- out_max and index retain the last result until the next DONE; they are zero only after reset.
- Reset mid-operation (any state): immediate return to reset condition; the partial frame is discarded.
- Counter wrap: sample_cnt, n and lag each count 0..length-1 and return to 0. length must be ≤ 2^length_counter_bits.

Optional Feature:
- Macro X_CORR_LINEAR_LAG_EN.
- Defined: linear (zero-padded) correlation. A term is skipped (contributes 0) when n+lag ≥ length. Timing and latency are unchanged.
- Undefined: circular indexing as above.
- Check, length=5: x[3]=(100,0), y[0]=(100,0), others 0.
  - Circular: index=2, out_max=10000.
  - Linear: out_max=0, index=0.

Test Plan:
All scenarios use default widths with out_max_bits=25 override, length=5.
- Autocorrelation impulse: x[0]=y[0]=(100,0), others 0 → s_axis_tvalid 26 cycles after the 5th accept; out_max=10000, index=0.
- Delayed impulse: x[0]=(100,0), y[3]=(50,0), others 0 → out_max=5000, index=3.
- Quadrature/conjugate: x[0]=(0,100), y[0]=(100,0) → acc_q=+10000, acc_i=0; out_max=10000, index=0.
- All-zero frame → out_max=0, index=0 (tie keeps lag 0).
- Backpressure: hold m_axis_tready=0 for 10 cycles in DONE → s_axis_tvalid stays 1, outputs stable, s_axis_tready=0. Then assert m_axis_tready one cycle → s_axis_tready=1 next cycle; a second frame is processed correctly.
- Reset during COMPUTE → next cycle after release s_axis_tvalid=0, s_axis_tready=1, out_max=0, index=0. A fresh impulse frame then gives out_max=10000.
